hazard_control_unit: RTL
========================

# hazard_control_unit

Pipeline hazard controller for the 5-stage core: the producer side of the stall/flush/forward signal set that the fetch-decode, decode-execute, execute-memory and memory-writeback pipeline registers consume. It keeps its own scoreboard of the instructions in E, M and W. From that it generates:
- operand-forwarding selects for the execute stage;
- load-use stalls;
- branch flushes;
- a multi-cycle data-memory wait stall, with timeout and a stall-cycle performance counter.

## Interface
Parameters:
- RF_AW, 4, register-file address width.
- WAIT_MAX, 255, maximum data-memory wait cycles before timeout (1..255).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- d_valid  in  1  decode stage holds a real instruction.
- d_r1_addr, d_r2_addr  in  RF_AW  source registers of the decode instruction.
- d_rd_addr  in  RF_AW  destination register of the decode instruction.
- d_reg_write  in  1  decode instruction writes the register file.
- d_mem_to_reg  in  1  decode instruction is a load.
- e_branch_taken  in  1  branch resolved taken in execute this cycle (PCSrc).
- m_mem_req  in  1  memory-stage instruction is accessing data memory.
- m_mem_ready  in  1  data memory completes the access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1  1 = STALL (hold register), 0 = RUN.
- flush_d, flush_e  out  1  active-low: 0 = FLUSH (load bubble), 1 = KEEP.
- forward_ae, forward_be  out  2  0 = ID_EX (register-file value), 1 = MEM_WB, 2 = EX_MEM; 3 is never driven.
- mem_timeout  out  1  one-cycle pulse when a memory wait hits WAIT_MAX.
- stall_cycles  out  32  saturating count of cycles with stall_f = STALL.

## Operation
Scoreboard:
- The E entry holds {valid, rd, reg_write, is_load, r1, r2}.
- The M and W entries hold {valid, rd, reg_write, is_load}.
- All entries are invalid at reset.

FSM:
- States: RUN and WAIT.
- RUN → WAIT when m_mem_req & ~m_mem_ready.
- WAIT → RUN when m_mem_ready, or when the wait counter reaches WAIT_MAX.
- The wait counter is 8 bits. It clears on entry to WAIT and increments each cycle spent in WAIT.

Condition `memwait` = m_mem_req & ~m_mem_ready. Its scope:
- In RUN it is evaluated combinationally, so the first cycle also stalls.
- In WAIT it applies until release.
- On the timeout cycle the stall is released and mem_timeout = 1.

Outputs by case. Priority is memwait > branch > load-use > normal.
- memwait:
  - All four stalls = STALL; flush_d = flush_e = KEEP.
  - Scoreboard: E and M hold, W ← bubble.
- Branch taken (e_branch_taken, no memwait):
  - stall_f = stall_d = RUN; flush_d = flush_e = FLUSH.
  - Scoreboard: W ← M, M ← E, E ← bubble.
- Load-use (E valid & reg_write & is_load & d_valid & (E.rd == d_r1_addr | E.rd == d_r2_addr)):
  - stall_f = stall_d = STALL; flush_e = FLUSH; flush_d = KEEP.
  - Scoreboard: W ← M, M ← E, E ← bubble.
- Normal:
  - All stalls RUN, flushes KEEP.
  - Scoreboard: W ← M, M ← E, E ← decode fields with valid = d_valid.
- stall_e and stall_m are STALL only in the memwait case.

Forwarding (combinational from scoreboard state; A uses E.r1, B uses E.r2):
- Output 2 if M is valid, reg_write, not a load, and M.rd matches.
- Otherwise output 1 if W is valid, reg_write, and W.rd matches.
- Otherwise output 0.
- An invalid E entry forces 0.
- An M-stage load match is never forwarded.

Other rules:
- stall_cycles increments on each clock with stall_f = STALL and saturates at 0xFFFF_FFFF.
- Register 15 is compared like any other address.

## Timing
- Reset values, held while rst = 1:
  - stall_* = RUN, flush_d = flush_e = FLUSH, forward_* = 0.
  - mem_timeout = 0, stall_cycles = 0, FSM = RUN, scoreboard invalid.
- First cycle after reset release: flushes = KEEP.
- Stall, flush and forward outputs are combinational from current state and same-cycle inputs; zero-cycle latency.
- Load-use costs exactly one stall cycle. On the next cycle the load is in M with a bubble in E; the consumer then enters E and gets forward = 1.
- e_branch_taken held during memwait is acted on in the first cycle after release.
- Reset asserted mid-WAIT returns the FSM to RUN immediately and clears the counter.
- mem_timeout asserts on the cycle the counter equals WAIT_MAX; that same cycle has stalls = RUN.

## Test plan
- Back-to-back ALU: writer of r3 followed by a reader of r3 in src A → forward_ae = 2 when the reader is in E. A reader two behind → forward_ae = 1. An unrelated register → 0.
- Load r5, next instruction reads r5 as src B → one cycle of stall_f = stall_d = STALL with flush_e = FLUSH; next cycle forward_be = 1; stall_cycles = 1.
- e_branch_taken coincident with a load-use match → flush_d = flush_e = FLUSH, stall_f = RUN (branch wins).
- m_mem_req = 1 with m_mem_ready low for 3 cycles → 3 cycles of all stalls asserted, W bubble, FSM returns to RUN on the ready cycle, stall_cycles = 3.
- WAIT_MAX = 4 and memory never ready → mem_timeout pulses once on the 4th WAIT cycle and stalls drop that cycle.
- rst asserted during WAIT → FSM = RUN, flushes = FLUSH, counters 0, forward_* = 0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage core: tracks the E/M/W instructions and
// produces stall, flush and forwarding controls plus a data-memory wait FSM.
module hazard_control_unit #(
   parameter int RF_AW    = 4,
   parameter int WAIT_MAX = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d_valid,
   input  logic [RF_AW-1:0] d_r1_addr,
   input  logic [RF_AW-1:0] d_r2_addr,
   input  logic [RF_AW-1:0] d_rd_addr,
   input  logic             d_reg_write,
   input  logic             d_mem_to_reg,
   input  logic             e_branch_taken,
   input  logic             m_mem_req,
   input  logic             m_mem_ready,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic [1:0]       forward_ae,
   output logic [1:0]       forward_be,
   output logic             mem_timeout,
   output logic [31:0]      stall_cycles
);

   localparam logic       STALL    = 1'b1;
   localparam logic       RUN      = 1'b0;
   localparam logic       FLUSH    = 1'b0;
   localparam logic       KEEP     = 1'b1;
   localparam logic [1:0] FWD_RF   = 2'd0;
   localparam logic [1:0] FWD_WB   = 2'd1;
   localparam logic [1:0] FWD_MEM  = 2'd2;
   localparam logic [8:0] WAIT_LIM = 9'(WAIT_MAX);

   typedef enum logic {ST_RUN, ST_WAIT} state_e;

   typedef struct packed {
      logic             valid;
      logic [RF_AW-1:0] rd;
      logic             reg_write;
      logic             is_load;
   } stage_t;

   typedef struct packed {
      stage_t           op;
      logic [RF_AW-1:0] r1;
      logic [RF_AW-1:0] r2;
   } ex_t;

   state_e      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   ex_t         e_q, e_d;
   stage_t      m_q, m_d, w_q, w_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [8:0]  wait_next;
   logic        mem_pending;
   logic        timeout;
   logic        memwait;
   logic        load_use;

   function automatic logic [1:0] fwd_sel(input logic e_valid, input logic [RF_AW-1:0] src,
                                          input stage_t m, input stage_t w);
      if (!e_valid)                                               return FWD_RF;
      else if (m.valid && m.reg_write && !m.is_load && m.rd == src) return FWD_MEM;
      else if (w.valid && w.reg_write && w.rd == src)               return FWD_WB;
      else                                                          return FWD_RF;
   endfunction

   // NOTE: sequential state uses non-blocking assignments only; all next-state values
   // come from the combinational blocks below.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         wait_cnt_q     <= '0;
         e_q            <= '0;
         m_q            <= '0;
         w_q            <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         e_q            <= e_d;
         m_q            <= m_d;
         w_q            <= w_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   // The wait count includes the current WAIT cycle, so the limit hits on the Nth WAIT cycle.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no latches are inferred.
      mem_pending = m_mem_req & ~m_mem_ready;
      wait_next   = {1'b0, wait_cnt_q} + 9'd1;
      timeout     = (state_q == ST_WAIT) & ~m_mem_ready & (wait_next == WAIT_LIM);
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      memwait     = 1'b0;
      case (state_q)
         ST_RUN: begin
            memwait = mem_pending;
            if (mem_pending) begin
               state_d    = ST_WAIT;
               wait_cnt_d = '0;
            end
         end
         ST_WAIT: begin
            memwait = ~m_mem_ready & ~timeout;
            if (memwait) wait_cnt_d = wait_next[7:0];
            else         state_d    = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      load_use = e_q.op.valid & e_q.op.reg_write & e_q.op.is_load & d_valid &
                 ((e_q.op.rd == d_r1_addr) | (e_q.op.rd == d_r2_addr));
      stall_f  = RUN;
      stall_d  = RUN;
      stall_e  = RUN;
      stall_m  = RUN;
      flush_d  = KEEP;
      flush_e  = KEEP;
      e_d      = {d_valid, d_rd_addr, d_reg_write, d_mem_to_reg, d_r1_addr, d_r2_addr};
      m_d      = e_q.op;
      w_d      = m_q;
      if (memwait) begin
         stall_f = STALL;
         stall_d = STALL;
         stall_e = STALL;
         stall_m = STALL;
         e_d     = e_q;
         m_d     = m_q;
         w_d     = '0;
      end else if (e_branch_taken) begin
         flush_d = FLUSH;
         flush_e = FLUSH;
         e_d     = '0;
      end else if (load_use) begin
         stall_f = STALL;
         stall_d = STALL;
         flush_e = FLUSH;
         e_d     = '0;
      end
      // NOTE: the FSM sits in RUN during reset yet sees live memory inputs, so the
      // controls are forced here to keep the pipeline registers flushed and running.
      if (rst) begin
         stall_f = RUN;
         stall_d = RUN;
         stall_e = RUN;
         stall_m = RUN;
         flush_d = FLUSH;
         flush_e = FLUSH;
      end
   end

   assign stall_cycles_d = (stall_f == STALL && stall_cycles_q != '1) ? stall_cycles_q + 32'd1
                                                                      : stall_cycles_q;
   assign stall_cycles   = stall_cycles_q;
   assign mem_timeout    = timeout & ~rst;
   assign forward_ae     = fwd_sel(e_q.op.valid, e_q.r1, m_q, w_q);
   assign forward_be     = fwd_sel(e_q.op.valid, e_q.r2, m_q, w_q);

endmodule
